// File: rtl/fifo_uart_pkg.sv
// Shared constants and state encoding for the FIFO-draining UART transmitter.
// Used by both the drain controller and the byte serialiser.
package fifo_uart_pkg;

   localparam int unsigned FRAME_BITS = 10;
   localparam int unsigned DATA_BITS  = FRAME_BITS - 2;

   function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                 input int unsigned baud);
      return clk_freq / baud;
   endfunction

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StCheck = 3'd1,
      StRead  = 3'd2,
      StLatch = 3'd3,
      StStart = 3'd4,
      StData  = 3'd5,
      StStop  = 3'd6,
      StNext  = 3'd7
   } state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, eight data bits LSB first, one stop bit.
// Owns the baud counter; can chain a new byte straight out of the last stop cycle.
module uart_tx_byte
   import fifo_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int unsigned      CNT_W    = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

   state_e           state;
   logic [CNT_W-1:0] baud_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift;
   logic             bit_end;

   assign bit_end = (baud_cnt == CNT_LAST);
   assign busy    = (state != StIdle);
   // High during the final cycle of the stop bit.
   assign done    = (state == StStop) && bit_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= StIdle;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         baud_cnt <= (state == StIdle || bit_end) ? '0 : baud_cnt + CNT_W'(1);
         unique case (state)
            StStart: begin
               if (bit_end) begin
                  state   <= StData;
                  tx      <= shift[0];
                  bit_idx <= '0;
               end
            end
            StData: begin
               if (bit_end) begin
                  if (bit_idx == BIT_LAST) begin
                     state <= StStop;
                     tx    <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                  end
               end
            end
            StStop: begin
               if (bit_end) state <= StIdle;
            end
            default: ;
         endcase
         // Accepting in the last stop cycle gives back-to-back frames with no idle gap.
         if (start && (state == StIdle || done)) begin
            state    <= StStart;
            tx       <= 1'b0;
            shift    <= data;
            baud_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the filter output FIFO on a send_i rising edge and sends each 16-bit
// word as two 8N1 UART bytes, high byte first; pulses done_o when the FIFO is empty.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 115_200,
   parameter int unsigned DATA_W   = 16
) (
   input  logic              clk_100MHz_i,
   input  logic              rst_n_i,
   input  logic              send_i,
   input  logic              empty_i,
   input  logic [DATA_W-1:0] dato_i,
   output logic              rd_o,
   output logic              tx_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);

   state_e     state;
   logic       send_q;
   logic       start;
   logic       byte_sel;
   logic [7:0] lo_byte;
   logic       byte_start;
   logic       byte_busy;
   logic       byte_done;
   logic [7:0] byte_data;

   assign start = send_i & ~send_q;

   // High byte launches from dato_i while it is still valid in LATCH; the low byte
   // chains off the high byte's last stop cycle. StStart here means "byte in flight".
   assign byte_start = (state == StLatch && !byte_busy) ||
                       (state == StStart && byte_done && !byte_sel);
   assign byte_data  = (state == StLatch) ? dato_i[DATA_W-1 -: 8] : lo_byte;

   always_ff @(posedge clk_100MHz_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= StIdle;
         send_q   <= 1'b0;
         byte_sel <= 1'b0;
         lo_byte  <= '0;
         rd_o     <= 1'b0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         send_q <= send_i;
         rd_o   <= 1'b0;
         done_o <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  state  <= StCheck;
                  busy_o <= 1'b1;
               end
            end
            StCheck: begin
               if (empty_i) begin
                  state  <= StIdle;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end else begin
                  state <= StRead;
                  rd_o  <= 1'b1;
               end
            end
            StRead:  state <= StLatch;
            StLatch: begin
               lo_byte  <= dato_i[7:0];
               byte_sel <= 1'b0;
               state    <= StStart;
            end
            StStart: begin
               if (byte_done) begin
                  if (!byte_sel) byte_sel <= 1'b1;
                  else           state    <= StNext;
               end
            end
            StNext:  state <= StCheck;
            default: state <= StIdle;
         endcase
      end
   end

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_tx_byte (
      .clk   (clk_100MHz_i),
      .rst_n (rst_n_i),
      .start (byte_start),
      .data  (byte_data),
      .tx    (tx_o),
      .busy  (byte_busy),
      .done  (byte_done)
   );

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model, UART line decoder and an expected-byte scoreboard.
module tb_fifo_uart_tx;

   localparam int BAUD_DIV  = 868;
   localparam int FRAME_CYC = 10 * BAUD_DIV;
   localparam int WORD_BUSY = 2 * FRAME_CYC + 4;

   typedef struct {
      logic [7:0] data;
      int         gap;
   } exp_t;

   logic        clk_100MHz_i = 1'b0;
   logic        rst_n_i;
   logic        send_i;
   logic        empty_i;
   logic [15:0] dato_i;
   logic        rd_o;
   logic        tx_o;
   logic        busy_o;
   logic        done_o;

   logic [15:0] fifo_q[$];
   exp_t        exp_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int rd_cnt = 0, done_cnt = 0, busy_cnt = 0;
   int rd_mid = 0, overlap = 0, underflow = 0;
   int done_cyc = 0, frame_end = 0;
   bit in_frame = 1'b0;
   bit mon_en = 1'b0;
   bit force_empty = 1'b0;

   fifo_uart_tx dut (
      .clk_100MHz_i (clk_100MHz_i),
      .rst_n_i      (rst_n_i),
      .send_i       (send_i),
      .empty_i      (empty_i),
      .dato_i       (dato_i),
      .rd_o         (rd_o),
      .tx_o         (tx_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk_100MHz_i = ~clk_100MHz_i;

   always @(posedge clk_100MHz_i) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic push_word(input logic [15:0] w, input bit first);
      exp_t e;
      fifo_q.push_back(w);
      e.data = w[15:8];
      e.gap  = first ? -1 : 4;
      exp_q.push_back(e);
      e.data = w[7:0];
      e.gap  = 0;
      exp_q.push_back(e);
   endtask

   task automatic pulse_send();
      @(negedge clk_100MHz_i);
      send_i = 1'b1;
      repeat (5) @(negedge clk_100MHz_i);
      send_i = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int limit);
      int n = 0;
      while (done_cnt == d0 && n < limit) begin
         @(negedge clk_100MHz_i);
         n++;
      end
      if (done_cnt == d0) check("done_timeout", 0, 1);
   endtask

   // FIFO read side: data presented after rd_o, then replaced by garbage.
   initial begin : fifo_model
      int hold = 0;
      forever begin
         @(negedge clk_100MHz_i);
         if (rd_o === 1'b1) begin
            rd_cnt++;
            if (in_frame) rd_mid++;
            if (done_o === 1'b1) overlap++;
            if (fifo_q.size() == 0) underflow++;
            else dato_i = fifo_q.pop_front();
            hold = 2;
         end else if (hold > 0) begin
            hold--;
            if (hold == 0) dato_i = 16'h5AA5;
         end
         if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (busy_o === 1'b1) busy_cnt++;
         empty_i = (fifo_q.size() == 0) || force_empty;
      end
   end

   // UART decoder: every cycle of every bit must hold the bit's value.
   initial begin : uart_mon
      exp_t       e;
      logic [9:0] frame;
      int         bad;
      int         start_cyc;
      forever begin
         @(negedge clk_100MHz_i);
         if (mon_en && tx_o === 1'b0) begin
            in_frame  = 1'b1;
            start_cyc = cyc;
            bad       = 0;
            for (int b = 0; b < 10; b++) begin
               for (int c = 0; c < BAUD_DIV; c++) begin
                  if (b != 0 || c != 0) @(negedge clk_100MHz_i);
                  if (c == 0) frame[b] = tx_o;
                  else if (tx_o !== frame[b]) bad++;
               end
            end
            in_frame = 1'b0;
            if (exp_q.size() == 0) begin
               check("frame_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("frame_start_stop", {frame[9], frame[0]}, 2'b10);
               check("frame_data", frame[8:1], e.data);
               check("bit_width", bad, 0);
               if (e.gap >= 0) check("frame_gap", start_cyc - frame_end, e.gap);
            end
            frame_end = start_cyc + FRAME_CYC;
         end
      end
   end

   initial begin : main
      int d0, r0, b0, n, lat, tx_low;
      rst_n_i = 1'b0;
      send_i  = 1'b0;
      empty_i = 1'b1;
      dato_i  = '0;

      repeat (10) @(negedge clk_100MHz_i);
      check("rst_tx", tx_o, 1);
      check("rst_rd", rd_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      rst_n_i = 1'b1;

      // Reset in the middle of a data bit that is driving 0.
      fifo_q.push_back(16'h1234);
      @(negedge clk_100MHz_i);
      send_i = 1'b1;
      n = 0;
      while (tx_o !== 1'b0 && n < 20) begin
         @(negedge clk_100MHz_i);
         n++;
      end
      check("mr_start_seen", tx_o, 0);
      send_i = 1'b0;
      repeat (BAUD_DIV + 400) @(negedge clk_100MHz_i);
      check("mr_data_low", tx_o, 0);
      rst_n_i = 1'b0;
      #1;
      check("mr_rst_tx", tx_o, 1);
      check("mr_rst_busy", busy_o, 0);
      repeat (3) @(negedge clk_100MHz_i);
      rst_n_i = 1'b1;
      repeat (5) @(negedge clk_100MHz_i);

      // Empty drain.
      d0 = done_cnt;
      r0 = rd_cnt;
      lat = -1;
      tx_low = 0;
      @(negedge clk_100MHz_i);
      send_i = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk_100MHz_i);
         if (done_o === 1'b1 && lat < 0) lat = i;
         if (tx_o !== 1'b1) tx_low++;
      end
      send_i = 1'b0;
      repeat (10) begin
         @(negedge clk_100MHz_i);
         if (tx_o !== 1'b1) tx_low++;
      end
      check("empty_done_lat", (lat >= 1 && lat <= 3), 1);
      check("empty_done_cnt", done_cnt - d0, 1);
      check("empty_rd_cnt", rd_cnt - r0, 0);
      check("empty_tx_idle", tx_low, 0);

      // Single word.
      mon_en = 1'b1;
      push_word(16'hA53C, 1'b1);
      d0 = done_cnt;
      r0 = rd_cnt;
      b0 = busy_cnt;
      pulse_send();
      wait_done(d0, 20000);
      repeat (20) @(negedge clk_100MHz_i);
      check("w1_rd_cnt", rd_cnt - r0, 1);
      check("w1_done_cnt", done_cnt - d0, 1);
      check("w1_busy_cyc", busy_cnt - b0, WORD_BUSY + 1);
      check("w1_done_pos", done_cyc - frame_end, 2);
      check("w1_frames_left", exp_q.size(), 0);

      // Three words, with a send retrigger and an empty glitch mid-frame.
      push_word(16'h0001, 1'b1);
      push_word(16'h8000, 1'b0);
      push_word(16'hFFFF, 1'b0);
      d0 = done_cnt;
      r0 = rd_cnt;
      b0 = busy_cnt;
      pulse_send();
      repeat (14000 - 5) @(negedge clk_100MHz_i);
      pulse_send();
      repeat (20000 - 14006) @(negedge clk_100MHz_i);
      force_empty = 1'b1;
      repeat (100) @(negedge clk_100MHz_i);
      force_empty = 1'b0;
      wait_done(d0, 60000);
      repeat (20) @(negedge clk_100MHz_i);
      check("w3_rd_cnt", rd_cnt - r0, 3);
      check("w3_done_cnt", done_cnt - d0, 1);
      check("w3_busy_cyc", busy_cnt - b0, 3 * WORD_BUSY + 1);
      check("w3_done_pos", done_cyc - frame_end, 2);
      check("w3_frames_left", exp_q.size(), 0);

      check("rd_mid_frame", rd_mid, 0);
      check("rd_done_overlap", overlap, 0);
      check("fifo_underflow", underflow, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
